reg_writeback_unit: RTL
=======================

// Module: reg_writeback_unit
// PURPOSE
//  Write-side driver for the 32x32 register bank: sole owner of its single write port
//  (reg_write / write_reg / write_data). Merges single-cycle ALU results with
//  variable-latency load results. Loads are buffered in a small queue.
//  Loads drain only in cycles with no ALU write. WAW ordering is kept by killing stale queued loads.
//  Sits between execute/memory stages and register_bank; pending[] feeds the hazard/stall logic.
// PARAMETERS
//  DATA_W      32  register data width
//  REG_ADDR_W  5   register index width (32 registers)
//  DEPTH       4   load queue entries (power of 2, >=2)
// PORTS
//  clock          in   1           rising-edge clock
//  reset          in   1           synchronous, active-high reset
//  alu_valid      in   1           ALU result present this cycle (no backpressure)
//  alu_rd         in   REG_ADDR_W  ALU destination register
//  alu_data       in   DATA_W      ALU result
//  ld_valid       in   1           load result offered
//  ld_ready       out  1           load result accepted when ld_valid&ld_ready
//  ld_rd          in   REG_ADDR_W  load destination register
//  ld_data        in   DATA_W      load data
//  wb_reg_write   out  1           to register_bank.reg_write
//  wb_write_reg   out  REG_ADDR_W  to register_bank.write_reg
//  wb_write_data  out  DATA_W      to register_bank.write_data
//  pending        out  32          bit r set = live queued load targets register r
//  queue_count    out  log2(DEPTH)+1  occupied queue slots (live + killed)
// BEHAVIOUR
//  - Clock is "clock", reset is "reset"; reset is synchronous and active-high, single clock domain.
//  - Reset: wb_* = 0, queue empty (count 0, all entry valid bits 0), pending = 0, ld_ready = 1 next cycle.
//    Reset wins over every other event in the same cycle; in-flight queued loads are discarded.
//  - wb_* are registered outputs, updated every edge; wb_reg_write is 0 in any cycle with no write.
//  - ALU path: alu_valid && alu_rd!=0 at edge t -> wb_reg_write=1, wb_write_reg/data=ALU values after t.
//    Latency 1. alu_rd==0 -> no write, no kill.
//  - Load path: accepted load is pushed to the queue tail; never bypasses the queue.
//    Minimum latency 2 edges from acceptance to wb_* update.
//    ld_rd==0 -> handshake completes, entry not enqueued.
//  - ld_ready = (queue_count < DEPTH), derived from the registered count. A full queue plus a same-cycle pop
//    still shows ready=0.
//  - Drain: in a cycle with no ALU write and a non-empty queue, the head pops.
//    Live head -> wb write of head rd/data. Killed head -> pops silently, wb_reg_write=0.
//  - Ordering rule: an ALU result is always program-younger than every queued or incoming load.
//    ALU write to rd=X at edge t clears the valid bit of every queued entry with rd==X.
//    Same-cycle incoming load with rd==X is accepted, then enqueued already killed.
//  - Simultaneous push+pop: legal; count unchanged; tail/head pointers wrap modulo DEPTH.
//  - pending = OR over live entries of onehot(rd); bit 0 always 0; updated on same edge as queue.
//  - Writes to register 0 are never issued on wb_*.
// STRUCTURE
//  - Shared package mips_pkg: DATA_W, REG_ADDR_W, NUM_REGS=32, REG_ZERO=5'd0.
//    Also holds typedef wb_entry_t {valid, rd, data}.
//  - Sub-module wb_load_queue: circular buffer of wb_entry_t, head/tail/count.
//    Inputs: push, pop, kill_en, kill_rd. Outputs: head entry, count, pending vector.
//  - Top level: ALU-vs-queue select, rd==0 filtering, registered wb_* outputs.
// TESTING
//  1 Reset mid-drain: 3 loads queued, assert reset 1 cycle.
//    -> wb_reg_write=0, queue_count=0, pending=0; no queued load ever written.
//  2 ALU only: alu_valid, rd=5, data=32'hDEAD_BEEF at edge t.
//    -> after t: wb_reg_write=1, wb_write_reg=5, data=DEADBEEF; next idle cycle wb_reg_write=0.
//  3 Load latency: single load rd=7, data=0x1234, accepted at t, no ALU traffic.
//    -> write of 7/0x1234 visible after t+1; pending[7] high for exactly one cycle.
//  4 Fill/backpressure: ALU busy every cycle, 5 loads offered -> 4 accepted, ld_ready=0 on the 5th.
//    Drop alu_valid -> 4 writes in FIFO order, ld_ready returns to 1 after the first pop.
//  5 WAW kill: queue loads rd=9 (0xAA) and rd=3 (0xBB); ALU writes rd=9 (0xCC).
//    -> pending[9]=0, drains emit 9/0xCC, then rd=3 only; no 0xAA write ever.
//  6 Zero register: ALU rd=0 and load rd=0 issued -> no wb write, no queue entry, pending[0]=0.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-bank widths and write-back queue entry type
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_load_queue.sv
// rtl/wb_load_queue.sv - circular buffer of pending load write-backs with rd-based kill
module wb_load_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic [REG_ADDR_W-1:0]   push_rd,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  input  logic                    kill_en,
  input  logic [REG_ADDR_W-1:0]   kill_rd,
  output logic                    head_valid,
  output logic [REG_ADDR_W-1:0]   head_rd,
  output logic [DATA_W-1:0]       head_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic [NUM_REGS-1:0]     pending
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i].valid <= 1'b0;
    end else begin
      // A younger ALU write to the same rd makes queued loads stale.
      if (kill_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (mem[i].rd == kill_rd) mem[i].valid <= 1'b0;
        end
      end
      if (pop) begin
        mem[head].valid <= 1'b0;
        head            <= head + 1'b1;
      end
      if (push) begin
        mem[tail] <= '{valid: !(kill_en && (push_rd == kill_rd)), rd: push_rd, data: push_data};
        tail      <= tail + 1'b1;
      end
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  assign head_valid = mem[head].valid;
  assign head_rd    = mem[head].rd;
  assign head_data  = mem[head].data;

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i].valid) pending[mem[i].rd] = 1'b1;
    end
    pending[REG_ZERO] = 1'b0;
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// rtl/reg_writeback_unit.sv - merges ALU results and queued load results onto the register-bank write port
module reg_writeback_unit #(
  parameter int DATA_W     = mips_pkg::DATA_W,
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
  parameter int DEPTH      = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   alu_valid,
  input  logic [REG_ADDR_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [REG_ADDR_W-1:0]  ld_rd,
  input  logic [DATA_W-1:0]      ld_data,
  output logic                   wb_reg_write,
  output logic [REG_ADDR_W-1:0]  wb_write_reg,
  output logic [DATA_W-1:0]      wb_write_data,
  output logic [31:0]            pending,
  output logic [$clog2(DEPTH):0] queue_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                  alu_write;
  logic                  push;
  logic                  pop;
  logic                  head_valid;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0]     head_data;

  assign alu_write = alu_valid && (alu_rd != mips_pkg::REG_ZERO);
  // Ready comes from the registered count only, so a full queue stays not-ready even while popping.
  assign ld_ready  = (queue_count < CW'(DEPTH));
  assign push      = ld_valid && ld_ready && (ld_rd != mips_pkg::REG_ZERO);
  assign pop       = !alu_write && (queue_count != '0);

  wb_load_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_rd    (ld_rd),
    .push_data  (ld_data),
    .pop        (pop),
    .kill_en    (alu_write),
    .kill_rd    (alu_rd),
    .head_valid (head_valid),
    .head_rd    (head_rd),
    .head_data  (head_data),
    .count      (queue_count),
    .pending    (pending)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_reg_write  <= 1'b0;
      wb_write_reg  <= '0;
      wb_write_data <= '0;
    end else if (alu_write) begin
      wb_reg_write  <= 1'b1;
      wb_write_reg  <= alu_rd;
      wb_write_data <= alu_data;
    end else if (pop && head_valid) begin
      wb_reg_write  <= 1'b1;
      wb_write_reg  <= head_rd;
      wb_write_data <= head_data;
    end else begin
      wb_reg_write  <= 1'b0;
      wb_write_reg  <= '0;
      wb_write_data <= '0;
    end
  end

endmodule
